// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared constants and types for the instruction fetch unit.
//   INST_NOP         - instruction presented when no fetched word is valid
//   DEFAULT_RESET_PC - default value of the ifu_fetch RESET_PC parameter
//   fetch_entry_t    - {addr, inst} pair held in the response buffer
//   align_word()     - clears the byte-offset bits of an address
package ifu_fetch_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// ifu_fetch_fifo: synchronous FIFO with flush and occupancy count.
//   Used both as the {addr,inst} response buffer and as the in-order
//   tag queue of granted PCs.
// Parameters: WIDTH (entry width), DEPTH (entries, power of 2, >= 2)
// Ports:
//   clk, rst      clock / asynchronous active-low reset
//   flush         empties the FIFO (wins over push/pop)
//   push, push_data   write an entry (ignored when full and not popping)
//   pop           remove head entry (ignored when empty)
//   head_data     current head entry (combinational)
//   empty, full, count   occupancy status
module ifu_fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty     = (cnt == '0);
  assign full      = (cnt == (AW + 1)'(DEPTH));
  assign count     = cnt;
  assign head_data = mem[rd_ptr];
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW + 1)'(1);
        2'b01:   cnt <= cnt - (AW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit. Owns the PC, issues requests on the
// instruction-memory bus, buffers returned words and presents them to IF/ID.
// Parameters: RESET_PC, FIFO_DEPTH (buffer entries = max outstanding requests)
// Ports:
//   clk, rst                 clock / asynchronous active-low reset
//   hold_i                   decode stall, head entry is kept
//   jump_en_i, jump_addr_i   one-cycle redirect from EX
//   imem_req_o, imem_addr_o, imem_gnt_i          request channel
//   imem_rvalid_i, imem_rdata_i                  in-order response channel
//   inst_o, inst_addr_o, inst_valid_o            IF/ID outputs
//   perf_fetch_cnt_o, perf_bubble_cnt_o          only with IFU_PERF_EN defined
// Macro IFU_PERF_EN adds the fetch/bubble performance counters.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_bubble_cnt_o
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] discard;
  logic [CW-1:0] discard_nxt;
  logic [CW:0]   occupancy;

  logic          xfer;
  logic          accept;
  logic          resp_keep;
  logic          resp_drop;
  logic          data_pop;

  fetch_entry_t  data_in;
  fetch_entry_t  data_head;
  logic          data_empty;
  logic [CW-1:0] data_count;
  logic [31:0]   tag_head;
  logic          tag_empty;

  logic          data_full_unused;
  logic          tag_full_unused;
  logic [CW-1:0] tag_count_unused;

  // Occupancy only falls without a grant, so a raised request stays raised
  // (with a stable PC) until it is granted or a jump withdraws it.
  assign occupancy   = {1'b0, outstanding} + {1'b0, data_count};
  assign imem_req_o  = rst && (occupancy < {1'b0, DEPTH_C}) && !jump_en_i;
  assign imem_addr_o = pc;

  assign xfer      = imem_req_o && imem_gnt_i;
  // A grant during a jump is still owed a response, which will be stale.
  assign accept    = imem_gnt_i && (imem_req_o || jump_en_i);
  assign resp_drop = imem_rvalid_i && (discard != '0);
  assign resp_keep = imem_rvalid_i && (discard == '0) && !jump_en_i && !tag_empty;
  assign data_pop  = !data_empty && !hold_i && !jump_en_i;

  assign data_in = '{addr: tag_head, inst: imem_rdata_i};

  ifu_fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (jump_en_i),
    .push      (resp_keep),
    .push_data (data_in),
    .pop       (data_pop),
    .head_data (data_head),
    .empty     (data_empty),
    .full      (data_full_unused),
    .count     (data_count)
  );

  ifu_fetch_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (jump_en_i),
    .push      (xfer),
    .push_data (pc),
    .pop       (resp_keep),
    .head_data (tag_head),
    .empty     (tag_empty),
    .full      (tag_full_unused),
    .count     (tag_count_unused)
  );

  always_comb begin
    outstanding_nxt = outstanding;
    if (imem_rvalid_i && (outstanding != '0)) outstanding_nxt = outstanding_nxt - CW'(1);
    if (accept && (outstanding_nxt != DEPTH_C)) outstanding_nxt = outstanding_nxt + CW'(1);

    // After a jump every response still owed belongs to the old stream.
    discard_nxt = discard;
    if (jump_en_i)      discard_nxt = outstanding_nxt;
    else if (resp_drop) discard_nxt = discard - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      if (jump_en_i)  pc <= align_word(jump_addr_i);
      else if (xfer)  pc <= pc + 32'd4;
    end
  end

  always_comb begin
    inst_o       = INST_NOP;
    inst_addr_o  = '0;
    inst_valid_o = 1'b0;
    if (!data_empty && !jump_en_i) begin
      inst_o       = data_head.inst;
      inst_addr_o  = data_head.addr;
      inst_valid_o = 1'b1;
    end
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt_o  <= '0;
      perf_bubble_cnt_o <= '0;
    end else begin
      if (data_pop)              perf_fetch_cnt_o  <= perf_fetch_cnt_o + 32'd1;
      if (!hold_i && data_empty) perf_bubble_cnt_o <= perf_bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule
